// File: rtl/cram_compute_ctrl_if.sv
// cram_compute_ctrl_if: start/done handshake plus the internal BRAM port-a/port-b signals.
interface cram_compute_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 40
);
  logic          start;
  logic          external;
  logic [AW:0]   num_words;
  logic [AW-1:0] in_start_addr;
  logic [AW-1:0] out_start_addr;
  logic [AW-1:0] bram_addr_b;
  logic [DW-1:0] bram_rdata_b;
  logic [AW-1:0] bram_addr_a;
  logic [DW-1:0] bram_wdata_a;
  logic          bram_wren_a;
  logic          busy;
  logic          done;
  modport master (
    output start, external, num_words, in_start_addr, out_start_addr, bram_rdata_b,
    input  bram_addr_b, bram_addr_a, bram_wdata_a, bram_wren_a, busy, done
  );
  modport slave (
    input  start, external, num_words, in_start_addr, out_start_addr, bram_rdata_b,
    output bram_addr_b, bram_addr_a, bram_wdata_a, bram_wren_a, busy, done
  );
endinterface

// File: rtl/cram_compute_ctrl.sv
// cram_compute_ctrl: streams operand words from BRAM port b, adds packed 8-bit pairs, writes sums on port a.
module cram_compute_ctrl #(
  parameter int BRAM_DWIDTH     = 40,
  parameter int BRAM_AWIDTH     = 9,
  parameter int COMPUTE_DWIDTH  = 8,
  parameter int BRAM_LATENCY    = 1,
  parameter int COMPUTE_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cram_compute_ctrl_if.slave  bus
);
  localparam int LANES = BRAM_DWIDTH / (2 * COMPUTE_DWIDTH);
  localparam int RW    = COMPUTE_DWIDTH + 1;
  localparam int OS    = 2 * RW;
  localparam int CW    = BRAM_AWIDTH + 1;
  localparam logic [COMPUTE_LATENCY-1:0] CV_MASK = {COMPUTE_LATENCY{1'b1}} >> 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BRAM_AWIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, last_a_q;
  logic [BRAM_LATENCY-1:0]    rv_q;
  logic [COMPUTE_LATENCY-1:0] cv_q;
  logic [BRAM_DWIDTH-1:0]     cd_q [COMPUTE_LATENCY];
  logic [BRAM_DWIDTH-1:0]     sum;
  logic accept, abort, rd_en, wren;
  assign accept = (state_q == IDLE || state_q == DONE) && bus.start && !bus.external;
  assign abort  = (state_q == RUN || state_q == DRAIN) && bus.external;
  assign rd_en  = state_q == RUN && !bus.external;
  assign wren   = cv_q[COMPUTE_LATENCY-1] && !bus.external;
  assign bus.bram_addr_b  = rd_addr_q;
  assign bus.bram_addr_a  = wren ? wr_addr_q : last_a_q;
  assign bus.bram_wdata_a = wren ? cd_q[COMPUTE_LATENCY-1] : '0;
  assign bus.bram_wren_a  = wren;
  assign bus.busy         = state_q == RUN || state_q == DRAIN;
  assign bus.done         = state_q == DONE;
  always_comb begin
    sum = '0;
    for (int j = 0; j < LANES; j++)
      sum[j*OS +: RW] = {1'b0, bus.bram_rdata_b[j*2*COMPUTE_DWIDTH +: COMPUTE_DWIDTH]}
                      + {1'b0, bus.bram_rdata_b[j*2*COMPUTE_DWIDTH+COMPUTE_DWIDTH +: COMPUTE_DWIDTH]};
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = accept ? bus.out_start_addr : wren ? wr_addr_q + BRAM_AWIDTH'(1) : wr_addr_q;
    if (accept) begin
      state_d   = bus.num_words == '0 ? DONE : RUN;
      cnt_d     = bus.num_words;
      rd_addr_d = bus.in_start_addr;
    end else if (abort) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      cnt_d     = cnt_q - CW'(1);
      rd_addr_d = rd_addr_q + BRAM_AWIDTH'(1);
      state_d   = cnt_q == CW'(1) ? DRAIN : RUN;
    end else if (state_q == DRAIN && rv_q == '0 && (cv_q & CV_MASK) == '0) begin
      // only the output stage may still hold a word; it is written this cycle
      state_d = DONE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      last_a_q  <= '0;
      rv_q      <= '0;
      cv_q      <= '0;
      for (int i = 0; i < COMPUTE_LATENCY; i++) cd_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      if (wren) last_a_q <= wr_addr_q;
      rv_q <= abort ? '0 : (rv_q << 1) | BRAM_LATENCY'(rd_en);
      cv_q <= abort ? '0 : (cv_q << 1) | COMPUTE_LATENCY'(rv_q[BRAM_LATENCY-1]);
      cd_q[0] <= sum;
      for (int i = 1; i < COMPUTE_LATENCY; i++) cd_q[i] <= cd_q[i-1];
    end
  end
endmodule

// File: tb/tb_cram_compute_ctrl.sv
// tb_cram_compute_ctrl: BRAM model plus scoreboard of expected writes (address, data, cycle).
module tb_cram_compute_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [39:0] mem [512];
  typedef struct {logic [8:0] a; logic [39:0] d; int t;} exp_t;
  exp_t q[$];
  cram_compute_ctrl_if #(.AW(9), .DW(40)) bus ();
  cram_compute_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    bus.bram_rdata_b <= mem[bus.bram_addr_b];
    if (bus.bram_wren_a) mem[bus.bram_addr_a] <= bus.bram_wdata_a;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [39:0] model(input logic [39:0] w);
    logic [8:0] s0, s1;
    s0 = {1'b0, w[7:0]} + {1'b0, w[15:8]};
    s1 = {1'b0, w[23:16]} + {1'b0, w[31:24]};
    return {13'b0, s1, 9'b0, s0};
  endfunction
  always @(negedge clk) begin
    if (bus.bram_wren_a) begin
      if (q.size() == 0) check("unexpected_wr", {55'b0, bus.bram_addr_a}, 64'hDEAD);
      else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", bus.bram_addr_a, e.a);
        check("wr_data", bus.bram_wdata_a, e.d);
        check("wr_cyc", cyc, e.t);
      end
    end else if (bus.bram_wdata_a != '0) check("idle_wdata", bus.bram_wdata_a, 0);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic at_cycle(input int t);
    for (int i = 0; i < 4000 && cyc < t; i++) tick();
  endtask
  task automatic start_run(input int n, input logic [8:0] in_a, input logic [8:0] out_a,
                           input int npush, output int t);
    exp_t e;
    bus.start = 1;
    bus.num_words = 10'(n);
    bus.in_start_addr = in_a;
    bus.out_start_addr = out_a;
    t = cyc + 1;
    for (int k = 0; k < npush; k++) begin
      e.a = out_a + 9'(k);
      e.d = model(mem[in_a + 9'(k)]);
      e.t = t + k + 3;
      q.push_back(e);
    end
    tick();
    bus.start = 0;
  endtask
  task automatic wait_done(input string tag, input int exp_t);
    for (int i = 0; i < 2000 && !bus.done; i++) tick();
    check(tag, cyc, exp_t);
  endtask
  task automatic check_all_zero(input string tag);
    check(tag, {bus.bram_addr_b, bus.bram_addr_a, bus.bram_wdata_a, bus.bram_wren_a, bus.busy, bus.done}, 0);
  endtask
  initial begin
    int t;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    for (int i = 10; i < 14; i++) mem[i] = 40'h00_3412_01FF;
    bus.start = 0;
    bus.external = 0;
    bus.num_words = 0;
    bus.in_start_addr = 0;
    bus.out_start_addr = 0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst_n = 1;
    tick();
    check_all_zero("post_reset_idle");
    // basic run with fixed operand words
    start_run(4, 9'd10, 9'd100, 4, t);
    check("busy_run", bus.busy, 1);
    wait_done("done_n4", t + 7);
    check("lit_data", mem[100], 40'h00_0118_0100);
    check("busy_done", bus.busy, 0);
    // zero-length run
    start_run(0, 9'd20, 9'd200, 0, t);
    check("zero_done", bus.done, 1);
    check("zero_busy", bus.busy, 0);
    repeat (5) tick();
    check("zero_busy_later", bus.busy, 0);
    // address wrap
    start_run(4, 9'd510, 9'd511, 4, t);
    wait_done("done_wrap", t + 7);
    // abort at T+2, start held with external
    start_run(8, 9'd30, 9'd300, 0, t);
    at_cycle(t + 2);
    bus.external = 1;
    bus.start = 1;
    #1;
    check("abort_wren", bus.bram_wren_a, 0);
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    repeat (6) tick();
    check("ext_start_ignored", {bus.busy, bus.done}, 0);
    bus.external = 0;
    bus.start = 0;
    tick();
    start_run(2, 9'd40, 9'd400, 2, t);
    wait_done("done_after_abort", t + 5);
    // abort in the cycle of the second write: first write survives only
    start_run(8, 9'd50, 9'd350, 1, t);
    at_cycle(t + 4);
    bus.external = 1;
    #1;
    check("abort_same_cycle", bus.bram_wren_a, 0);
    tick();
    bus.external = 0;
    repeat (8) tick();
    check("abort2_idle", {bus.busy, bus.done}, 0);
    // start while busy is ignored
    start_run(6, 9'd60, 9'd160, 6, t);
    at_cycle(t + 2);
    bus.start = 1;
    bus.num_words = 10'd2;
    bus.in_start_addr = 9'd300;
    bus.out_start_addr = 9'd5;
    tick();
    bus.start = 0;
    wait_done("done_busy_ignored", t + 9);
    // restart from DONE
    start_run(3, 9'd70, 9'd170, 3, t);
    check("done_clears", bus.done, 0);
    check("restart_busy", bus.busy, 1);
    wait_done("done_restart", t + 6);
    // reset pulse mid-run
    start_run(8, 9'd80, 9'd180, 0, t);
    at_cycle(t + 2);
    rst_n = 0;
    #1;
    check_all_zero("midrun_reset");
    tick();
    rst_n = 1;
    repeat (12) tick();
    check_all_zero("after_reset_idle");
    // full memory in place
    start_run(512, 9'd0, 9'd0, 512, t);
    wait_done("done_full", t + 515);
    tick();
    check("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
